// File: rtl/div16_8_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
// master drives operands and result acceptance; slave is the divider.
interface div16_8_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] P;
  logic [WIDTH-1:0]   B;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   Q;
  logic [WIDTH-1:0]   R;
  logic               ovf;
  logic               dbz;

  modport master (
    output in_valid,
    output P,
    output B,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  Q,
    input  R,
    input  ovf,
    input  dbz
  );

  modport slave (
    input  in_valid,
    input  P,
    input  B,
    input  out_ready,
    output in_ready,
    output out_valid,
    output Q,
    output R,
    output ovf,
    output dbz
  );
endinterface

// File: rtl/div16_8_seq.sv
// Restoring divider, 2W/W bits, one quotient bit per cycle.
// Define DIV_ROUND_EN for round-half-up quotients.
module div16_8_seq #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  div16_8_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic             ovf_r;
  logic             dbz_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
`ifdef DIV_ROUND_EN
  logic             rnd;
`endif

  // rem < div always holds, so the W-bit subtract cannot wrap
  always_comb begin
    t      = {rem, dvd[WIDTH-1]};
    ge     = (t >= {1'b0, div});
    rem_nx = ge ? (t[WIDTH-1:0] - div) : t[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], ge};
`ifdef DIV_ROUND_EN
    rnd    = ({rem_nx, 1'b0} >= {1'b0, div});
`endif
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.Q         = q_r;
  assign bus.R         = r_r;
  assign bus.ovf       = ovf_r;
  assign bus.dbz       = dbz_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      dvd   <= '0;
      quo   <= '0;
      div   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      ovf_r <= 1'b0;
      dbz_r <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            div <= bus.B;
            if (bus.B == '0) begin
              dbz_r <= 1'b1;
              ovf_r <= 1'b0;
              q_r   <= '1;
              r_r   <= bus.P[WIDTH-1:0];
              state <= DONE;
            end else if (bus.P[2*WIDTH-1:WIDTH] >= bus.B) begin
              ovf_r <= 1'b1;
              dbz_r <= 1'b0;
              q_r   <= '1;
              r_r   <= '0;
              state <= DONE;
            end else begin
              ovf_r <= 1'b0;
              dbz_r <= 1'b0;
              rem   <= bus.P[2*WIDTH-1:WIDTH];
              dvd   <= bus.P[WIDTH-1:0];
              quo   <= '0;
              cnt   <= CW'(WIDTH - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            r_r   <= rem_nx;
`ifdef DIV_ROUND_EN
            if (rnd && (&quo_nx)) begin
              q_r   <= quo_nx;
              ovf_r <= 1'b1;
            end else if (rnd) begin
              q_r <= quo_nx + 1'b1;
            end else begin
              q_r <= quo_nx;
            end
`else
            q_r <= quo_nx;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/div16_8_seq.md
Name: div16_8_seq

Overview:
- Sequential restoring divider; the inverse operation of the team's 8x8 multipliers.
- Divides a 2*WIDTH-bit product-domain dividend by a WIDTH-bit divisor, one quotient bit per cycle.
- Used to recover an operand from a product (exact or approximate) and to measure multiplier error in characterisation harnesses.
- Valid/ready handshake on both the input and output sides; one operation in flight.

Parameters:
- WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands P/B valid.
- in_ready  output  1  block can accept operands.
- P  input  2*WIDTH  dividend.
- B  input  WIDTH  divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Q  output  WIDTH  quotient.
- R  output  WIDTH  remainder.
- ovf  output  1  quotient does not fit in WIDTH bits.
- dbz  output  1  divide by zero.

Behaviour:
- Reset: rst_n low clears all state asynchronously, independent of clk.
  - State goes to IDLE.
  - in_ready=1, out_valid=0, Q=0, R=0, ovf=0, dbz=0.
- Reset mid-operation: any operation in flight is abandoned with no output.
- FSM states: IDLE, CALC, DONE.
- in_ready = (state==IDLE), driven purely from state.
- out_valid = (state==DONE), driven purely from state.
- Accept on an edge where in_valid && in_ready. P and B are captured and need not be held afterwards.
  - B==0: dbz=1, ovf=0, Q=all ones, R=P[WIDTH-1:0]; go to DONE.
  - Else if P[2W-1:W] >= B: ovf=1, dbz=0, Q=all ones, R=0; go to DONE.
  - Else: ovf=0, dbz=0. Load partial remainder rem (WIDTH+1 bits) with P[2W-1:W], shift register with P[W-1:0], counter=WIDTH-1; go to CALC.
- CALC, each cycle:
  - t = {rem[W-1:0], next dividend bit, MSB first}.
  - If t >= B: rem = t - B, shift in quotient bit 1; else rem = t, shift in 0.
  - Decrement counter. On the cycle the counter is 0, go to DONE with Q = quotient and R = rem[W-1:0].
- Latency:
  - Normal operation: out_valid rises exactly WIDTH+1 edges after the accept edge (accept edge, then WIDTH CALC edges).
  - dbz/ovf cases: out_valid rises 1 edge after accept.
- DONE:
  - Q/R/ovf/dbz held stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready: go to IDLE. Outputs keep their last values; they are don't-care when out_valid=0.
- Throughput: no accept while busy. A new accept can occur at the earliest on the edge after the handshake completes, since in_ready rises in IDLE.
- in_valid is ignored outside IDLE; out_ready is ignored outside DONE.
- Arithmetic: unsigned only.
  - The comparison uses WIDTH+1 bits, so no wrap is possible.
  - Invariant for non-ovf/dbz results: P == Q*B + R and R < B.

Optional Feature:
- Macro: DIV_ROUND_EN.
- Defined: on the CALC->DONE transition, if 2*R >= B, Q is incremented (round-half-up). R is unchanged and is still the truncating remainder.
  - If the increment would exceed all ones, Q stays all ones and ovf is set.
  - No extra cycle of latency. dbz/ovf early-exit paths are unaffected.
- Undefined: Q is the truncated quotient; no rounding logic is present.

Test Plan:
- Basic: P=1000, B=10 → Q=100, R=0, ovf=0, dbz=0; out_valid exactly 9 edges after accept.
- Remainder: P=0x00FE, B=15 → Q=16, R=14. With DIV_ROUND_EN: Q=17, R=14.
- Divide by zero: P=0x1234, B=0 → dbz=1, Q=0xFF, R=0x34; out_valid 1 edge after accept.
- Overflow: P=0xFFFF, B=0xFF → ovf=1, Q=0xFF, R=0.
  - Also P=0xFE01, B=0xFF → Q=0xFF, R=0, ovf=0 (largest legal quotient).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, while in_valid=1 with new operands → Q/R stable, in_ready=0 throughout. Release → handshake, IDLE, next operands accepted on the following edge.
- Reset mid-CALC: assert rst_n=0 at the 4th CALC cycle, asynchronously between edges → in_ready=1 and out_valid=0 immediately, no result emitted. A following P=4096, B=64 op → Q=64, R=0.
